mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (fetch stage miss path) and the data cache (mem stage miss path) of the pipelined lc3b core.
- Accepts line read/write requests from both caches and grants one at a time.
- Holds the grant until the memory responds, then routes the response back to the owner.
- Data cache has fixed priority because the mem stage holds the older instruction.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word)
- LINE_W, 128, cache line width in bits
- STARVE_LIMIT, 4, consecutive dcache grants with icache waiting before icache is forced (used only with the optional feature)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- icache_read  in  1  icache line read request, held until icache_resp
- icache_address  in  ADDR_W  icache line address
- icache_rdata  out  LINE_W  line data to icache
- icache_resp  out  1  one-cycle completion pulse to icache
- dcache_read  in  1  dcache line read request, held until dcache_resp
- dcache_write  in  1  dcache writeback request, held until dcache_resp; never asserted together with dcache_read
- dcache_address  in  ADDR_W  dcache line address
- dcache_wdata  in  LINE_W  writeback line
- dcache_rdata  out  LINE_W  line data to dcache
- dcache_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_W  memory line address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

Behaviour:
- State register: IDLE, I_BUSY, D_BUSY, RECOVER.
- Reset:
  - State goes to IDLE.
  - All strobes and resp outputs are 0; pmem_address/pmem_wdata are 0.
  - The starve counter is cleared.
  - Reset mid-transaction abandons the transaction immediately; any later pmem_resp is ignored while in IDLE.
- IDLE:
  - No pmem strobes.
  - If dcache_read|dcache_write, the next state is D_BUSY.
  - Otherwise, if icache_read, the next state is I_BUSY.
  - Otherwise, stay in IDLE.
  - When both caches request in the same cycle, dcache wins.
- D_BUSY:
  - pmem_read=dcache_read, pmem_write=dcache_write, pmem_address=dcache_address, pmem_wdata=dcache_wdata.
  - On pmem_resp: dcache_resp=1 and dcache_rdata=pmem_rdata in the same cycle (combinational pass-through), and the next state is RECOVER.
- I_BUSY:
  - pmem_read=1, pmem_write=0, pmem_address=icache_address.
  - On pmem_resp: icache_resp=1 and icache_rdata=pmem_rdata in the same cycle, and the next state is RECOVER.
- RECOVER:
  - Lasts exactly one cycle with no strobes and no grant.
  - Absorbs the requester's deassertion cycle so a stale request is never re-granted.
  - The next state is always IDLE.
- Latency:
  - A request seen in IDLE at cycle t drives pmem strobes from cycle t+1.
  - Minimum gap between back-to-back grants is 2 cycles (RECOVER, IDLE).
- Outputs are driven only in the owning state:
  - rdata outputs are 0 when the matching resp is 0.
  - Non-owner resp is always 0.
- Request deasserted while in BUSY (protocol violation): the strobes follow the request inputs; the arbiter stays in BUSY until pmem_resp.
- pmem_resp in IDLE or RECOVER is ignored.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A counter (width $clog2(STARVE_LIMIT+1)) increments on each IDLE->D_BUSY transition taken while icache_read=1.
  - The counter clears on any IDLE->I_BUSY transition, and saturates at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and icache_read=1 in IDLE, icache is granted even if dcache requests.
- When undefined: strict dcache priority, and no counter logic is present.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles during an active D_BUSY -> next cycle pmem_read=pmem_write=0, state IDLE; a pmem_resp 3 cycles later produces no dcache_resp.
- Single icache miss: icache_read=1, address 0x1230 at t -> pmem_read=1, pmem_address=0x1230 at t+1; pmem_resp with rdata 0xDEADBEEF... at t+5 -> icache_resp=1 with same data at t+5, strobes low at t+6.
- Collision: icache_read and dcache_read (0x4000) both rise at t -> pmem_address=0x4000 at t+1; after dcache_resp, RECOVER, IDLE, then icache granted 3 cycles after dcache_resp.
- Writeback: dcache_write=1, wdata 0x0123..CDEF, address 0x8010 -> pmem_write=1 with matching data/address; pmem_read=0 throughout; dcache_resp on pmem_resp.
- Stale-request guard: icache holds icache_read=1 for one cycle after icache_resp -> no second pmem_read issued for that address.
- Starvation (feature on, STARVE_LIMIT=4): dcache requests continuously with icache_read=1 -> exactly 4 dcache grants, then icache granted; with the feature off, icache is never granted while dcache requests.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache line-request ports and the shared pmem line port
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  icache_read, icache_address, dcache_read, dcache_write,
        input  dcache_address, dcache_wdata, pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output icache_read, icache_address, dcache_read, dcache_write,
        output dcache_address, dcache_wdata, pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the pmem line port between icache and dcache, dcache first; MEM_ARB_STARVE_GUARD_EN adds an icache anti-starvation counter
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_t;

    state_t state_q, state_d, cur;
    logic   d_req, force_i, d_grant, i_grant;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    assign force_i = starve_q == LIMIT;

    // Count dcache wins over a waiting icache, saturating; an icache win clears it
    always_comb begin
        starve_d = starve_q;
        if (i_grant) starve_d = '0;
        else if (d_grant && bus.icache_read && starve_q != LIMIT) starve_d = starve_q + 1'b1;
    end

    // Starve counter register
    always_ff @(posedge clk) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    // Strict dcache priority: icache is never forced ahead
    assign force_i = STARVE_LIMIT < 0;
`endif

    // Grant decision, owner-only muxing of the pmem port and response routing
    always_comb begin
        cur              = reset_n ? state_q : IDLE;
        d_req            = bus.dcache_read | bus.dcache_write;
        i_grant          = cur == IDLE && bus.icache_read && (!d_req || force_i);
        d_grant          = cur == IDLE && d_req && !i_grant;
        state_d          = cur;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {ADDR_W{1'b0}};
        bus.pmem_wdata   = {LINE_W{1'b0}};
        bus.icache_resp  = 1'b0;
        bus.icache_rdata = {LINE_W{1'b0}};
        bus.dcache_resp  = 1'b0;
        bus.dcache_rdata = {LINE_W{1'b0}};
        case (cur)
            IDLE: state_d = d_grant ? D_BUSY : i_grant ? I_BUSY : IDLE;
            D_BUSY: begin
                bus.pmem_read    = bus.dcache_read;
                bus.pmem_write   = bus.dcache_write;
                bus.pmem_address = bus.dcache_address;
                bus.pmem_wdata   = bus.dcache_wdata;
                bus.dcache_resp  = bus.pmem_resp;
                bus.dcache_rdata = bus.pmem_resp ? bus.pmem_rdata : {LINE_W{1'b0}};
                state_d          = bus.pmem_resp ? RECOVER : D_BUSY;
            end
            I_BUSY: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = bus.icache_address;
                bus.icache_resp  = bus.pmem_resp;
                bus.icache_rdata = bus.pmem_resp ? bus.pmem_rdata : {LINE_W{1'b0}};
                state_d          = bus.pmem_resp ? RECOVER : I_BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
endmodule
